fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 stall  input  1  decode cannot accept; output payload holds.
REQ-005 redirectValid  input  1  branch/jump/trap/MRET redirect, implies flush of fetch.
REQ-006 redirectTarget  input  32  new fetch address; bits [1:0] ignored (forced 0).
REQ-007 imemRequestValid  output  1  instruction read request.
REQ-008 imemRequestReady  input  1  memory accepts request this cycle.
REQ-009 imemAddress  output  32  word-aligned fetch address.
REQ-010 imemResponseValid  input  1  read data valid, earliest one cycle after acceptance.
REQ-011 imemResponseData  input  32  instruction word.
REQ-012 fetchDecodePayload  output  97  fetchDecodePayload_ {instruction, programCounter, programCounterPlus4, valid}, registered.

Function
REQ-013 The block SHALL keep fetchPC (next request address) and requestPC (address of the in-flight request).
REQ-014 States SHALL be REQ (may issue), WAIT (one request outstanding), DRAIN (outstanding response to discard).
REQ-015 At most one request SHALL be outstanding at any time.
REQ-016 imemRequestValid SHALL be (state==REQ) && (!payload.valid || !stall) && !redirectValid; it may deassert without a handshake.
REQ-017 imemAddress SHALL equal fetchPC.
REQ-018 On handshake (imemRequestValid && imemRequestReady): requestPC <= fetchPC, fetchPC <= fetchPC+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000), state -> WAIT.
REQ-019 In WAIT with imemResponseValid and no redirect: payload <= {imemResponseData, requestPC, requestPC+4 mod 2^32, 1}, state -> REQ.
REQ-020 The issue rule SHALL guarantee the payload register is empty or drained when a response lands; no response is ever dropped except in DRAIN.
REQ-021 Payload SHALL clear valid on the cycle after it is consumed (valid && !stall) unless a new response loads it that cycle.
REQ-022 While stall && payload.valid, all payload fields SHALL hold stable.
REQ-023 redirectValid SHALL: clear payload.valid next cycle, set fetchPC <= {redirectTarget[31:2], 2'b00}, override stall.
REQ-024 redirectValid in REQ -> REQ; in WAIT with no response this cycle -> DRAIN; in WAIT with response this cycle -> response discarded, REQ.
REQ-025 In DRAIN, imemResponseValid SHALL be discarded (payload unchanged) and state -> REQ; redirect in DRAIN updates fetchPC and stays DRAIN unless the response arrives that cycle (then REQ).
REQ-026 imemResponseValid outside WAIT/DRAIN SHALL be ignored.
REQ-027 Peak throughput SHALL be one instruction per two cycles with single-cycle memory and no stall.
REQ-028 The block SHALL perform no decode, misalignment or access-fault checking.

Reset
REQ-029 On reset assertion, immediately: fetchPC=resetVector (0x80000000), requestPC=0, state=REQ, fetchDecodePayload all zero (valid=0).
REQ-030 Reset asserted mid-request SHALL abandon the in-flight request; responses arriving after reset release in REQ are ignored.
REQ-031 First request after reset release SHALL present imemAddress=0x80000000.

Verification
REQ-032 Reset release, ready=1, 1-cycle memory returning 0x00000013 -> payload {0x00000013, 0x80000000, 0x80000004, 1}; next request address 0x80000004.
REQ-033 Payload valid, stall=1 for 5 cycles -> payload stable, imemRequestValid=0; stall=0 -> next request issued same cycle.
REQ-034 Request accepted at 0x80000010, redirectValid with target 0x80000103 before response -> DRAIN, response discarded, next request 0x80000100, no payload.valid for 0x80000010.
REQ-035 fetchPC=0xFFFFFFFC accepted -> payload programCounterPlus4=0x00000000, next imemAddress=0x00000000.
REQ-036 imemRequestReady=0 for 3 cycles -> fetchPC unchanged, imemAddress stable; ready=1 -> single handshake, single payload.
REQ-037 Reset asserted during WAIT, late response after release -> ignored, first payload from 0x80000000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles every non-clock signal of the fetch stage: the decode-side controls
// and payload, and the instruction-memory request/response channel.
//   stall              decode cannot accept; payload must hold
//   redirectValid      redirect (branch/jump/trap/MRET), flushes fetch
//   redirectTarget     new fetch address, low two bits ignored
//   imemRequestValid   read request to instruction memory
//   imemRequestReady   memory accepts the request this cycle
//   imemAddress        word-aligned fetch address
//   imemResponseValid  read data valid
//   imemResponseData   instruction word
//   fetchDecodePayload {instruction[96:65], pc[64:33], pc_plus4[32:1], valid[0]}
// Modport master is the fetch stage, slave is its environment.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        imemRequestValid;
    logic        imemRequestReady;
    logic [31:0] imemAddress;
    logic        imemResponseValid;
    logic [31:0] imemResponseData;
    logic [96:0] fetchDecodePayload;

    modport master (
        input  stall, redirectValid, redirectTarget,
        input  imemRequestReady, imemResponseValid, imemResponseData,
        output imemRequestValid, imemAddress, fetchDecodePayload
    );

    modport slave (
        output stall, redirectValid, redirectTarget,
        output imemRequestReady, imemResponseValid, imemResponseData,
        input  imemRequestValid, imemAddress, fetchDecodePayload
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch with a single outstanding memory request. Issues a read at
// fetch_pc, waits for the response and registers it, with its PC and PC+4,
// into the payload handed to decode. Redirects flush the payload and, if a
// request is still in flight, discard its response.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    fetch_stage_if.master (decode controls, imem channel, payload)
// ---------------------------------------------------------------------------
module fetch_stage (
    input  logic            clk,
    input  logic            reset,
    fetch_stage_if.master   bus
);
    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;

    // ST_WAIT: response pending and wanted; ST_DRAIN: response pending but
    // made stale by a redirect, so it is thrown away on arrival.
    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DRAIN} state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc;
    logic [31:0] request_pc;
    logic [31:0] pay_instr, pay_pc, pay_pc4;
    logic        pay_valid;
    logic        handshake;
    logic        load_payload;

    // A request is only issued when the payload register will be free by the
    // time the response lands (empty, or consumed this very cycle).
    assign bus.imemRequestValid   = (state == ST_REQ) && (!pay_valid || !bus.stall)
                                    && !bus.redirectValid;
    assign bus.imemAddress        = fetch_pc;
    assign bus.fetchDecodePayload = {pay_instr, pay_pc, pay_pc4, pay_valid};

    assign handshake    = bus.imemRequestValid && bus.imemRequestReady;
    assign load_payload = (state == ST_WAIT) && bus.imemResponseValid && !bus.redirectValid;

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_REQ: begin
                if (handshake) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imemResponseValid)  state_next = ST_REQ;
                else if (bus.redirectValid) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.imemResponseValid) state_next = ST_REQ;
            end
            default: state_next = ST_REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_REQ;
            fetch_pc   <= RESET_VECTOR;
            request_pc <= 32'h0;
        end else begin
            state <= state_next;
            if (bus.redirectValid)
                fetch_pc <= bus.redirectTarget & ~32'h3;
            else if (handshake)
                fetch_pc <= fetch_pc + 32'd4;
            if (handshake)
                request_pc <= fetch_pc;
        end
    end

    // Payload: redirect wins over everything, then a fresh response, then
    // consumption by decode. Only valid is cleared; the other fields hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pay_instr <= 32'h0;
            pay_pc    <= 32'h0;
            pay_pc4   <= 32'h0;
            pay_valid <= 1'b0;
        end else if (bus.redirectValid) begin
            pay_valid <= 1'b0;
        end else if (load_payload) begin
            pay_instr <= bus.imemResponseData;
            pay_pc    <= request_pc;
            pay_pc4   <= request_pc + 32'd4;
            pay_valid <= 1'b1;
        end else if (pay_valid && !bus.stall) begin
            pay_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed vector table for the documented scenarios, a throughput sequence,
// and a randomized run checked every cycle against a reference model that
// tracks "request outstanding / response unwanted" flags and the payload.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if bus();
    fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [96:0] act, input logic [96:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        rst, stall, redir;
        logic [31:0] target;
        logic        ready, resp;
        logic [31:0] data;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_pv;
        logic        full;       // compare all payload fields, not just valid
        logic [31:0] exp_instr, exp_pc, exp_pc4;
    } vec_t;

    function automatic vec_t mk(logic rst, logic stall, logic redir, logic [31:0] target,
                                logic ready, logic resp, logic [31:0] data,
                                logic exp_req, logic [31:0] exp_addr, logic exp_pv,
                                logic full, logic [31:0] ei, logic [31:0] ep, logic [31:0] ep4);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redir = redir; v.target = target;
        v.ready = ready; v.resp = resp; v.data = data;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_pv = exp_pv; v.full = full;
        v.exp_instr = ei; v.exp_pc = ep; v.exp_pc4 = ep4;
        return v;
    endfunction

    task automatic drive(input logic st, input logic rd, input logic [31:0] tg,
                         input logic rdy, input logic rv, input logic [31:0] dt);
        bus.stall             = st;
        bus.redirectValid     = rd;
        bus.redirectTarget    = tg;
        bus.imemRequestReady  = rdy;
        bus.imemResponseValid = rv;
        bus.imemResponseData  = dt;
    endtask

    // Instruction word the random-phase memory returns for an address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        // reference model state for the random phase
        logic [31:0] m_fetch, m_req, m_instr, m_pc, m_pc4, old_fetch;
        logic        m_pv, m_out, m_disc;
        logic        mem_busy;
        int          mem_cnt;
        logic [31:0] mem_data;
        logic        st, rd, rdy, rv, exp_req, hs, load;
        logic [31:0] tg, dt;
        int          n_hs, n_pv;
        logic        pend;

        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0);

        // rst stall redir target ready resp data | req addr pv full instr pc pc4
        vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1,32'h8000_0000,0,1,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h8000_0000,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h0000_0013,0,32'h8000_0004,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h8000_0004,1,1,32'h0000_0013,32'h8000_0000,32'h8000_0004));
        vecs.push_back(mk(0,1,0,32'h0,        1,1,32'h1111_1111,0,32'h8000_0008,0,0,32'h0,32'h0,32'h0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,0,32'h0,    1,0,32'h0,        0,32'h8000_0008,1,1,32'h1111_1111,32'h8000_0004,32'h8000_0008));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h8000_0008,1,1,32'h1111_1111,32'h8000_0004,32'h8000_0008));
        vecs.push_back(mk(0,0,0,32'h0,        0,1,32'h2222_2222,0,32'h8000_000C,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        1,32'h8000_000C,1,1,32'h2222_2222,32'h8000_0008,32'h8000_000C));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        1,32'h8000_000C,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        1,32'h8000_000C,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h8000_000C,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h3333_3333,0,32'h8000_0010,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h8000_0010,1,1,32'h3333_3333,32'h8000_000C,32'h8000_0010));
        vecs.push_back(mk(0,0,1,32'h8000_0103,1,0,32'h0,        0,32'h8000_0014,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h4444_4444,0,32'h8000_0100,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h8000_0100,0,1,32'h3333_3333,32'h8000_000C,32'h8000_0010));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h5555_5555,0,32'h8000_0104,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        1,32'h8000_0104,1,1,32'h5555_5555,32'h8000_0100,32'h8000_0104));
        vecs.push_back(mk(0,0,1,32'hFFFF_FFFF,1,0,32'h0,        0,32'h8000_0104,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'hFFFF_FFFC,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h6666_6666,0,32'h0000_0000,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        1,32'h0000_0000,1,1,32'h6666_6666,32'hFFFF_FFFC,32'h0000_0000));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h0000_0000,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1,32'h8000_0000,0,1,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        0,1,32'h7777_7777,1,32'h8000_0000,0,1,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h8000_0000,0,1,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h0000_0013,0,32'h8000_0004,0,1,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h8000_0004,1,1,32'h0000_0013,32'h8000_0000,32'h8000_0004));
        vecs.push_back(mk(0,0,1,32'h0000_1000,1,1,32'h8888_8888,0,32'h8000_0008,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h0000_1000,0,1,32'h0000_0013,32'h8000_0000,32'h8000_0004));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h9999_9999,0,32'h0000_1004,0,0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,1,0,32'h0,        1,0,32'h0,        0,32'h0000_1004,1,1,32'h9999_9999,32'h0000_1000,32'h0000_1004));
        vecs.push_back(mk(0,1,1,32'h0000_2000,1,0,32'h0,        0,32'h0000_1004,1,1,32'h9999_9999,32'h0000_1000,32'h0000_1004));
        vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        1,32'h0000_2000,0,1,32'h9999_9999,32'h0000_1000,32'h0000_1004));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            drive(vecs[i].stall, vecs[i].redir, vecs[i].target,
                  vecs[i].ready, vecs[i].resp, vecs[i].data);
            #1;
            check($sformatf("vec%0d req_valid", i), {96'h0, bus.imemRequestValid}, {96'h0, vecs[i].exp_req});
            check($sformatf("vec%0d address", i), {65'h0, bus.imemAddress}, {65'h0, vecs[i].exp_addr});
            if (vecs[i].full)
                check($sformatf("vec%0d payload", i), bus.fetchDecodePayload,
                      {vecs[i].exp_instr, vecs[i].exp_pc, vecs[i].exp_pc4, vecs[i].exp_pv});
            else
                check($sformatf("vec%0d payload_valid", i), {96'h0, bus.fetchDecodePayload[0]},
                      {96'h0, vecs[i].exp_pv});
        end

        // Peak throughput: single-cycle memory, ready, no stall -> one
        // request every two cycles.
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        pend = 1'b0; n_hs = 0; n_pv = 0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 0, 32'h0, 1, pend, 32'h0000_0013);
            #1;
            pend = bus.imemRequestValid;
            if (pend) n_hs++;
            if (bus.fetchDecodePayload[0]) n_pv++;
            @(negedge clk);
        end
        check("throughput handshakes", {65'h0, 32'(n_hs)}, {65'h0, 32'd10});
        check("throughput payloads", {65'h0, 32'(n_pv)}, {65'h0, 32'd9});

        // Randomized run against the reference model.
        reset = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_fetch = 32'h8000_0000; m_req = 32'h0;
        m_instr = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0; m_pv = 1'b0;
        m_out = 1'b0; m_disc = 1'b0;
        mem_busy = 1'b0; mem_cnt = 0; mem_data = 32'h0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            st  = ($urandom % 4) == 0;
            rd  = ($urandom % 12) == 0;
            tg  = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            rdy = ($urandom % 3) != 0;
            dt  = $urandom;
            rv  = 1'b0;
            if (mem_busy && mem_cnt == 0) begin
                rv = 1'b1;
                dt = mem_data;
            end else if (!mem_busy && ($urandom % 6) == 0) begin
                rv = 1'b1;
            end
            drive(st, rd, tg, rdy, rv, dt);
            #1;
            exp_req = !m_out && (!m_pv || !st) && !rd;
            check($sformatf("rand%0d req_valid", c), {96'h0, bus.imemRequestValid}, {96'h0, exp_req});
            check($sformatf("rand%0d address", c), {65'h0, bus.imemAddress}, {65'h0, m_fetch});
            check($sformatf("rand%0d payload", c), bus.fetchDecodePayload, {m_instr, m_pc, m_pc4, m_pv});

            // advance the model by one clock edge
            hs        = exp_req && rdy;
            old_fetch = m_fetch;
            load      = m_out && rv && !m_disc && !rd;
            if (m_out && rv) begin
                m_out = 1'b0;
                m_disc = 1'b0;
            end else if (m_out && rd) begin
                m_disc = 1'b1;
            end
            if (rd) m_pv = 1'b0;
            else if (load) begin
                m_instr = dt; m_pc = m_req; m_pc4 = m_req + 32'd4; m_pv = 1'b1;
            end else if (m_pv && !st) m_pv = 1'b0;
            if (rd) m_fetch = {tg[31:2], 2'b00};
            else if (hs) m_fetch = old_fetch + 32'd4;
            if (mem_busy && rv) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (hs) begin
                m_req    = old_fetch;
                m_out    = 1'b1;
                m_disc   = 1'b0;
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(1, 3) - 1;
                mem_data = mem_word(old_fetch);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
